// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK frame scheduler: FSM encoding, frame
// header byte and frame geometry helper.
package qpsk_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GRANT = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT,
        LOAD  = ST_LOAD,
        SEND  = ST_SEND,
        GAP   = ST_GAP
    } state_t;

    localparam logic [7:0] HDR_BYTE = 8'hFF;

    // Each QPSK symbol carries two bits of the frame.
    function automatic int sym_per_frame(input int frame_w);
        return frame_w / 2;
    endfunction

endpackage

// File: rtl/qpsk_rr_arb.sv
// Combinational round-robin picker: first valid requester at or above ptr,
// wrapping modulo NUM_REQ.
module qpsk_rr_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [2:0]         ptr,
    output logic [2:0]         grant,
    output logic               any_valid
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // rot_idx[k] is the requester sitting k positions after ptr.
    logic [2:0]         rot_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot_idx[gi]   = ((int'(ptr) + gi) >= NUM_REQ) ? 3'(int'(ptr) + gi - NUM_REQ)
                                                                 : 3'(int'(ptr) + gi);
            assign rot_valid[gi] = valid[IW'(rot_idx[gi])];
        end
    endgenerate

    always_comb begin
        grant     = 3'd0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[IW'(k)]) begin
                grant     = rot_idx[IW'(k)];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qpsk_frame_sched.sv
// Round-robin frame scheduler feeding one shared QPSK modulator.
// Optional header check enabled with `define QPSK_HDR_CHECK_EN.
module qpsk_frame_sched #(
    parameter int NUM_REQ     = 2,
    parameter int FRAME_W     = 40,
    parameter int CYC_PER_SYM = 100,
    parameter int GAP_CYC     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*FRAME_W-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [FRAME_W-1:0]         mod_data,
    output logic                       mod_load,
    output logic                       mod_busy,
    output logic                       sym_strobe,
    output logic [4:0]                 sym_idx,
    output logic [2:0]                 grant_id,
    output logic                       frame_done,
    output logic                       hdr_err
);

    import qpsk_pkg::*;

    localparam int NSYM = sym_per_frame(FRAME_W);
    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = (CYC_PER_SYM > 1) ? $clog2(CYC_PER_SYM) : 1;
    localparam int GW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t             state_reg, state_next;
    logic [2:0]         grant_reg;
    logic [2:0]         ptr_reg;
    logic [2:0]         grant_id_reg;
    logic [FRAME_W-1:0] mod_data_reg;
    logic [4:0]         sym_idx_reg;
    logic [CW-1:0]      cyc_cnt_reg;
    logic [GW-1:0]      gap_cnt_reg;
    // Set for the single post-frame cycle that carries frame_done.
    logic               done_reg;

    logic [2:0]         arb_grant;
    logic               arb_any;
    logic [NUM_REQ-1:0] grant_hit;
    logic               grant_valid;
    logic [FRAME_W-1:0] grant_frame;
    logic [FRAME_W-1:0] masked_frame [NUM_REQ];
    logic               hdr_ok;
    logic               sym_last;

    qpsk_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid     (req_valid),
        .ptr       (ptr_reg),
        .grant     (arb_grant),
        .any_valid (arb_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign grant_hit[gi]    = (grant_reg == 3'(gi));
            assign req_ready[gi]    = (state_reg == GRANT) && grant_hit[gi];
            assign masked_frame[gi] = grant_hit[gi] ? req_data[gi*FRAME_W +: FRAME_W] : '0;
        end
    endgenerate

    assign grant_valid = |(grant_hit & req_valid);

    always_comb begin
        grant_frame = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_frame = grant_frame | masked_frame[IW'(i)];
        end
    end

`ifdef QPSK_HDR_CHECK_EN
    assign hdr_ok  = (grant_frame[FRAME_W-1 -: 8] == HDR_BYTE) && (grant_frame[7:0] == HDR_BYTE);
    assign hdr_err = (state_reg == GRANT) && grant_valid && !hdr_ok;
`else
    assign hdr_ok  = 1'b1;
    assign hdr_err = 1'b0;
`endif

    assign sym_last = (sym_idx_reg == 5'(NSYM - 1)) && (cyc_cnt_reg == CW'(CYC_PER_SYM - 1));

    always_comb begin
        state_next = state_reg;
        mod_load   = 1'b0;
        mod_busy   = 1'b0;
        sym_strobe = 1'b0;
        frame_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en && arb_any) state_next = GRANT;
            end
            GRANT: begin
                state_next = (grant_valid && hdr_ok) ? LOAD : IDLE;
            end
            LOAD: begin
                mod_load   = 1'b1;
                mod_busy   = 1'b1;
                sym_strobe = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (done_reg) begin
                    frame_done = 1'b1;
                    state_next = (GAP_CYC == 0) ? IDLE : GAP;
                end else begin
                    mod_busy   = 1'b1;
                    sym_strobe = (cyc_cnt_reg == '0);
                end
            end
            GAP: begin
                if (gap_cnt_reg == GW'(GAP_CYC - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            ptr_reg      <= '0;
            grant_id_reg <= '0;
            mod_data_reg <= '0;
            sym_idx_reg  <= '0;
            cyc_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (en && arb_any) grant_reg <= arb_grant;
                end
                GRANT: begin
                    // A header-rejected frame is still consumed, so ptr advances either way.
                    if (grant_valid) begin
                        ptr_reg      <= (grant_reg == 3'(NUM_REQ - 1)) ? 3'd0 : grant_reg + 3'd1;
                        grant_id_reg <= grant_reg;
                        if (hdr_ok) mod_data_reg <= grant_frame;
                    end
                    sym_idx_reg <= '0;
                    cyc_cnt_reg <= '0;
                    done_reg    <= 1'b0;
                end
                LOAD, SEND: begin
                    gap_cnt_reg <= '0;
                    if (done_reg) begin
                        done_reg <= 1'b0;
                    end else if (sym_last) begin
                        done_reg <= 1'b1;
                    end else if (cyc_cnt_reg == CW'(CYC_PER_SYM - 1)) begin
                        cyc_cnt_reg <= '0;
                        sym_idx_reg <= sym_idx_reg + 5'd1;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + CW'(1);
                    end
                end
                GAP: begin
                    gap_cnt_reg <= gap_cnt_reg + GW'(1);
                end
                default: ;
            endcase
        end
    end

    assign mod_data = mod_data_reg;
    assign sym_idx  = sym_idx_reg;
    assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_qpsk_frame_sched.sv
// Directed bench for qpsk_frame_sched with NUM_REQ=2, CYC_PER_SYM=4, GAP_CYC=2.
`timescale 1ns/1ps
module tb_qpsk_frame_sched;

    localparam int NUM_REQ     = 2;
    localparam int FRAME_W     = 40;
    localparam int CYC_PER_SYM = 4;
    localparam int GAP_CYC     = 2;
    localparam int NSYM        = FRAME_W / 2;
    localparam int FRAME_CYC   = NSYM * CYC_PER_SYM;

    localparam logic [39:0] D0A = 40'hFF171819FF;
    localparam logic [39:0] D0B = 40'hFF00000AFF;
    localparam logic [39:0] D1A = 40'hFFA5A5A5FF;
    localparam logic [39:0] D1B = 40'hFF010203FF;
    localparam logic [39:0] BAD = 40'h0017181900;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       en  = 1'b0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ*FRAME_W-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]         req_ready;
    logic [FRAME_W-1:0]         mod_data;
    logic                       mod_load;
    logic                       mod_busy;
    logic                       sym_strobe;
    logic [4:0]                 sym_idx;
    logic [2:0]                 grant_id;
    logic                       frame_done;
    logic                       hdr_err;

    qpsk_frame_sched #(
        .NUM_REQ(NUM_REQ), .FRAME_W(FRAME_W), .CYC_PER_SYM(CYC_PER_SYM), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .mod_data(mod_data), .mod_load(mod_load), .mod_busy(mod_busy),
        .sym_strobe(sym_strobe), .sym_idx(sym_idx), .grant_id(grant_id),
        .frame_done(frame_done), .hdr_err(hdr_err)
    );

    always #5 clk = ~clk;

    longint cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_chk  = 0;
    int n_fail = 0;

    longint rdy_cyc[$], rdy_val[$], load_cyc[$], load_dat[$], load_gid[$];
    longint done_cyc[$], strobe_cyc[$], hdr_cyc[$];

    // Event log sampled on the falling edge, tagged with the current cycle number.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                rdy_cyc.push_back(cycle);
                rdy_val.push_back(longint'(req_ready));
            end
            if (mod_load) begin
                load_cyc.push_back(cycle);
                load_dat.push_back(longint'(mod_data));
                load_gid.push_back(longint'(grant_id));
            end
            if (frame_done) done_cyc.push_back(cycle);
            if (sym_strobe) strobe_cyc.push_back(cycle);
            if (hdr_err)    hdr_cyc.push_back(cycle);
        end
    end

    task automatic clear_logs();
        rdy_cyc.delete(); rdy_val.delete(); load_cyc.delete(); load_dat.delete();
        load_gid.delete(); done_cyc.delete(); strobe_cyc.delete(); hdr_cyc.delete();
    endtask

    function automatic longint qat(input longint q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [79:0] data;
        logic [1:0]  exp_ready;
        logic [39:0] exp_mod;
        logic [2:0]  exp_gid;
    } vec_t;

    vec_t   vecs[6];
    longint t0, e0;

    initial begin
        vecs[0] = '{2'b01, {D1A, D0A}, 2'b01, D0A, 3'd0};
        vecs[1] = '{2'b10, {D1A, D0A}, 2'b10, D1A, 3'd1};
        vecs[2] = '{2'b10, {D1B, D0A}, 2'b10, D1B, 3'd1};
        vecs[3] = '{2'b11, {D1B, D0B}, 2'b01, D0B, 3'd0};
        vecs[4] = '{2'b11, {D1A, D0B}, 2'b10, D1A, 3'd1};
        vecs[5] = '{2'b10, {D1B, D0A}, 2'b10, D1B, 3'd1};

        // Reset state
        #1;
        chk("reset mod_busy", longint'(mod_busy), 0);
        chk("reset req_ready", longint'(req_ready), 0);
        tick(3);
        rst = 1'b0;
        tick(2);
        chk("idle mod_data", longint'(mod_data), 0);
        chk("idle grant_id", longint'(grant_id), 0);
        chk("idle sym_idx", longint'(sym_idx), 0);

        // Single-frame vectors: latency, data, grant order
        for (int i = 0; i < 6; i++) begin
            clear_logs();
            t0 = cycle; en = 1'b1;
            req_valid = vecs[i].valid; req_data = vecs[i].data;
            tick(2);
            req_valid = '0;
            tick(FRAME_CYC + 5);
            $display("vec %0d: valid=%b grant_id=%0d mod_data=%h", i, vecs[i].valid, grant_id, mod_data);
            chk($sformatf("v%0d ready count", i), rdy_cyc.size(), 1);
            chk($sformatf("v%0d ready cycle", i), qat(rdy_cyc, 0) - t0, 1);
            chk($sformatf("v%0d ready value", i), qat(rdy_val, 0), longint'(vecs[i].exp_ready));
            chk($sformatf("v%0d load cycle", i), qat(load_cyc, 0) - t0, 2);
            chk($sformatf("v%0d load data", i), qat(load_dat, 0), longint'(vecs[i].exp_mod));
            chk($sformatf("v%0d grant_id", i), qat(load_gid, 0), longint'(vecs[i].exp_gid));
            chk($sformatf("v%0d strobes", i), strobe_cyc.size(), NSYM);
            chk($sformatf("v%0d last strobe", i), qat(strobe_cyc, NSYM - 1) - t0, 2 + (NSYM - 1) * CYC_PER_SYM);
            chk($sformatf("v%0d done cycle", i), qat(done_cyc, 0) - t0, 2 + FRAME_CYC);
            chk($sformatf("v%0d mod_data held", i), longint'(mod_data), longint'(vecs[i].exp_mod));
        end

        // Both requesters continuously valid: strict rotation
        clear_logs();
        t0 = cycle; req_data = {D1A, D0A}; req_valid = 2'b11;
        tick(300);
        req_valid = '0;
        tick(60);
        $display("rotation: %0d grants", rdy_cyc.size());
        chk("rr grant count", rdy_cyc.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr gid %0d", k), qat(load_gid, k), k % 2);
            chk($sformatf("rr data %0d", k), qat(load_dat, k), (k % 2 == 1) ? longint'(D1A) : longint'(D0A));
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rr done-to-ready %0d", k), qat(rdy_cyc, k + 1) - qat(done_cyc, k), GAP_CYC + 2);
        end

        // en dropped mid-SEND
        clear_logs();
        t0 = cycle; req_data = {D1A, D0B}; req_valid = 2'b01;
        tick(40);
        en = 1'b0;
        tick(160);
        $display("en-low: frames done=%0d grants=%0d", done_cyc.size(), rdy_cyc.size());
        chk("en0 done count", done_cyc.size(), 1);
        chk("en0 done cycle", qat(done_cyc, 0) - t0, 2 + FRAME_CYC);
        chk("en0 ready count", rdy_cyc.size(), 1);
        e0 = cycle; en = 1'b1;
        tick(2);
        req_valid = '0;
        tick(FRAME_CYC + 5);
        chk("en1 ready cycle", qat(rdy_cyc, 1) - e0, 1);
        chk("en1 grant_id", qat(load_gid, 1), 0);

        // Requester drops valid in its GRANT cycle
        clear_logs();
        t0 = cycle; req_data = {D1B, D0B}; req_valid = 2'b10;
        tick(1);
        req_valid = '0;
        tick(10);
        $display("drop: grants=%0d loads=%0d", rdy_cyc.size(), load_cyc.size());
        chk("drop ready cycle", qat(rdy_cyc, 0) - t0, 1);
        chk("drop ready value", qat(rdy_val, 0), 2);
        chk("drop load count", load_cyc.size(), 0);
        clear_logs();
        req_valid = 2'b11;
        tick(2);
        req_valid = '0;
        tick(FRAME_CYC + 5);
        chk("drop regrant value", qat(rdy_val, 0), 2);
        chk("drop regrant data", qat(load_dat, 0), longint'(D1B));

        // Async reset in the middle of symbol 10
        clear_logs();
        t0 = cycle; req_data = {D1B, D0A}; req_valid = 2'b01;
        tick(2);
        req_valid = '0;
        tick(41);
        chk("pre-rst sym_idx", longint'(sym_idx), 10);
        chk("pre-rst mod_busy", longint'(mod_busy), 1);
        #2 rst = 1'b1;
        #1;
        $display("rst mid-frame: busy=%0d sym_idx=%0d mod_data=%h", mod_busy, sym_idx, mod_data);
        chk("rst mod_busy", longint'(mod_busy), 0);
        chk("rst mod_data", longint'(mod_data), 0);
        chk("rst sym_idx", longint'(sym_idx), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(100);
        chk("rst no frame_done", done_cyc.size(), 0);
        clear_logs();
        t0 = cycle; req_valid = 2'b11;
        tick(2);
        req_valid = '0;
        tick(FRAME_CYC + 5);
        chk("rst ptr restart value", qat(rdy_val, 0), 1);
        chk("rst ptr restart data", qat(load_dat, 0), longint'(D0A));

        // Bad header frame
        clear_logs();
        t0 = cycle; req_data = {D1A, BAD}; req_valid = 2'b01;
        tick(2);
        req_valid = '0;
        tick(FRAME_CYC + 5);
        $display("bad header: grants=%0d loads=%0d hdr_err=%0d", rdy_cyc.size(), load_cyc.size(), hdr_cyc.size());
        chk("hdr ready cycle", qat(rdy_cyc, 0) - t0, 1);
`ifdef QPSK_HDR_CHECK_EN
        chk("hdr err count", hdr_cyc.size(), 1);
        chk("hdr err cycle", qat(hdr_cyc, 0) - t0, 1);
        chk("hdr load count", load_cyc.size(), 0);
        chk("hdr mod_data kept", longint'(mod_data), longint'(D0A));
`else
        chk("hdr err count", hdr_cyc.size(), 0);
        chk("hdr load data", qat(load_dat, 0), longint'(BAD));
        chk("hdr mod_data", longint'(mod_data), longint'(BAD));
`endif
        // Either way the frame was consumed, so requester 1 is next.
        clear_logs();
        req_valid = 2'b11;
        tick(2);
        req_valid = '0;
        tick(FRAME_CYC + 5);
        chk("post-hdr ptr value", qat(rdy_val, 0), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
